// File: rtl/mult_div_unit_if.sv
// Launch/result bundle between the control unit and the multiply/divide engine.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (output start, op, a, b, input busy, done, hi, lo, div_by_zero);
  modport slave  (input start, op, a, b, output busy, done, hi, lo, div_by_zero);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide engine (signed/unsigned MULT and DIV) feeding HI/LO.
// Optional feature macro: MULT_DIV_EARLY_EXIT_EN (MULT leaves CALC once the
// remaining multiplier bits are all zero).
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus
);
  localparam int unsigned AW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             is_signed, is_div_op, sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   add_sum, trial, rem_next;
  logic             q_bit;
  logic [AW-1:0]    mul_step, div_step;
  logic [CNT_W-1:0] cnt_dec;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Operand decode for the accept cycle: signs and exact magnitudes
  always_comb begin
    is_signed = ~bus.op[0];
    is_div_op = bus.op[1];
    sign_a    = is_signed & bus.a[WIDTH-1];
    sign_b    = is_signed & bus.b[WIDTH-1];
    mag_a     = sign_a ? WIDTH'(-{1'b1, bus.a}) : bus.a;
    mag_b     = sign_b ? WIDTH'(-{1'b1, bus.b}) : bus.b;
  end

  // One radix-2 step: shift-add for MULT, restoring shift-subtract for DIV
  always_comb begin
    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    mul_step = acc_q[0] ? ({add_sum, acc_q[WIDTH-1:0]} >> 1) : (acc_q >> 1);
    trial    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    q_bit    = (trial >= {1'b0, opb_q});
    rem_next = q_bit ? (trial - {1'b0, opb_q}) : trial;
    div_step = {rem_next, acc_q[WIDTH-2:0], q_bit};
    cnt_dec  = cnt_q - CNT_W'(1);
  end

  // Sign correction applied in FIX
  always_comb begin
    prod_fix = neg_q ? (-acc_q[2*WIDTH-1:0]) : acc_q[2*WIDTH-1:0];
    quo_fix  = neg_q ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    rem_fix  = rem_neg_q ? (-acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
  end

`ifdef MULT_DIV_EARLY_EXIT_EN
  logic [WIDTH-1:0] live_mask;
  logic             mul_idle;

  // Multiplier bits still to be consumed sit in the low cnt_dec positions
  always_comb begin
    live_mask = (WIDTH'(1) << cnt_dec) - WIDTH'(1);
    mul_idle  = ~is_div_q & ((mul_step[WIDTH-1:0] & live_mask) == '0);
  end
`endif

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      S_CALC: begin
        cnt_d = cnt_dec;
        acc_d = is_div_q ? div_step : mul_step;
        if (cnt_dec == '0) state_d = S_FIX;
`ifdef MULT_DIV_EARLY_EXIT_EN
        if (mul_idle) begin
          acc_d   = mul_step >> cnt_dec;
          state_d = S_FIX;
        end
`endif
      end
      S_FIX: begin
        state_d = S_DONE;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: begin
        state_d = S_IDLE;
        if (bus.start) begin
          dbz_d = is_div_op & (bus.b == '0);
          if (is_div_op && (bus.b == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_CALC;
            cnt_d     = CNT_W'(WIDTH);
            is_div_d  = is_div_op;
            neg_d     = sign_a ^ sign_b;
            rem_neg_d = is_div_op & sign_a;
            acc_d     = {{(WIDTH + 1){1'b0}}, (is_div_op ? mag_a : mag_b)};
            opb_d     = is_div_op ? mag_b : mag_a;
          end
        end
      end
    endcase

    busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized bench for mult_div_unit against a plain-arithmetic reference model.
module tb_mult_div_unit;
  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;
  logic [31:0] ref_hi;
  logic [31:0] ref_lo;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Architectural result computed with 64-bit integer arithmetic
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, sr, sq;
    longint unsigned ua, ub, ur, uq;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin sr = sa * sb; hi = sr[63:32]; lo = sr[31:0]; end
      2'b01: begin ur = ua * ub; hi = ur[63:32]; lo = ur[31:0]; end
      2'b10: begin sq = sa / sb; sr = sa % sb; hi = sr[31:0]; lo = sq[31:0]; end
      default: begin uq = ua / ub; ur = ua % ub; hi = ur[31:0]; lo = uq[31:0]; end
    endcase
  endfunction

  // Cycles from accept to the done pulse
  function automatic int exp_latency(input logic [1:0] op, input logic [31:0] b);
    int bits;
    logic [31:0] m;
    if (op[1] && b == 32'h0) return 1;
    bits = 32;
`ifdef MULT_DIV_EARLY_EXIT_EN
    if (!op[1]) begin
      m = (!op[0] && b[31]) ? (32'h0 - b) : b;
      bits = 1;
      for (int i = 0; i < 32; i++) if (m[i]) bits = i + 1;
    end
`else
    m = b;
`endif
    return bits + 2;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'($urandom_range(1, 15));
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int glitch_at, input bit check_gap);
    logic [31:0] e_hi, e_lo;
    bit   e_dbz, seen, busy_ok;
    int   lat, cyc;
    e_dbz = op[1] && (b == 32'h0);
    if (e_dbz) begin
      e_hi = ref_hi;
      e_lo = ref_lo;
    end else begin
      model(op, a, b, e_hi, e_lo);
    end
    lat = exp_latency(op, b);
    for (int i = 0; i < 200 && bus.busy !== 1'b0; i++) @(negedge clk);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 2'($urandom_range(0, 3));
    bus.a     = $urandom;
    bus.b     = $urandom;
    cyc = 0;
    seen = 1'b0;
    busy_ok = 1'b1;
    while (cyc < 100 && !seen) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && !e_dbz) check_eq("dbz_clear", 64'(bus.div_by_zero), 64'd0);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
      end else if (bus.busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
      if (!seen && glitch_at == cyc) begin
        bus.op    = 2'($urandom_range(0, 3));
        bus.a     = $urandom;
        bus.b     = 32'h0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
      end
    end
    check_eq("latency", 64'(cyc), 64'(lat));
    check_eq("hi", 64'(bus.hi), 64'(e_hi));
    check_eq("lo", 64'(bus.lo), 64'(e_lo));
    check_eq("dbz", 64'(bus.div_by_zero), 64'(e_dbz));
    check_eq("busy_window", 64'(busy_ok), 64'd1);
    ref_hi = e_hi;
    ref_lo = e_lo;
    if (check_gap) begin
      @(negedge clk);
      check_eq("done_pulse_width", 64'(bus.done), 64'd0);
      check_eq("idle_busy", 64'(bus.busy), 64'd0);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int dones;
    logic [1:0] rop;
    logic [31:0] ra, rb;
    int lat, g;
    n_total   = 0;
    n_bad     = 0;
    ref_hi    = '0;
    ref_lo    = '0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    check_eq("rst_hi", 64'(bus.hi), 64'd0);
    check_eq("rst_lo", 64'(bus.lo), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Directed corner cases
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, 1'b1);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 0, 1'b1);
    run_op(2'b11, 32'h0000_0451, 32'h20, 0, 1'b1);
    check_eq("pre_dbz_hi", 64'(bus.hi), 64'h11);
    check_eq("pre_dbz_lo", 64'(bus.lo), 64'h22);
    run_op(2'b11, 32'd100, 32'd0, 0, 1'b1);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);
    run_op(2'b00, 32'h1234_5678, 32'h8765_4321, 5, 1'b1);
    run_op(2'b10, 32'h7FFF_FFFF, 32'h8000_0000, 3, 1'b0);
    run_op(2'b00, 32'd5, 32'd3, 0, 1'b1);

    // Reset in the middle of a MULT aborts it without a done pulse
    for (int i = 0; i < 200 && bus.busy !== 1'b0; i++) @(negedge clk);
    bus.op    = 2'b00;
    bus.a     = $urandom;
    bus.b     = 32'h4000_0001;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("abort_busy", 64'(bus.busy), 64'd0);
    check_eq("abort_hi", 64'(bus.hi), 64'd0);
    check_eq("abort_lo", 64'(bus.lo), 64'd0);
    check_eq("abort_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) dones++;
    end
    check_eq("abort_no_done", 64'(dones), 64'd0);
    ref_hi = '0;
    ref_lo = '0;

    // Randomized traffic, often back-to-back with start in the DONE cycle
    for (int n = 0; n < 200; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = rand_operand();
      rb  = rand_operand();
      lat = exp_latency(rop, rb);
      g   = (lat > 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, lat - 1) : 0;
      run_op(rop, ra, rb, g, ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
